// File: rtl/rs232_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rs232_cmd_ctrl
// Pulls bytes from a UART receive FIFO, frames them into register-write
// packets and issues one write request per good packet.
//
// Packet (in order):  SYNC (P_SYNC_BYTE), ADDR, DATA [, CHK]
//   Build macro RS232_CMD_CTRL_CHKSUM_EN:
//     defined   -> 4-byte packet; CHK must equal (ADDR + DATA) mod 256.
//     undefined -> 3-byte packet; the write is issued straight after DATA
//                  and err_chksum is tied low.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx_fifo_empty  FIFO empty flag
//   rx_fifo_rd_en  one-cycle FIFO pop strobe
//   rx_fifo_dout   FIFO data, valid the cycle after rx_fifo_rd_en
//   reg_wr_req     write request, held until reg_wr_ack
//   reg_wr_addr    write address, stable while reg_wr_req is high
//   reg_wr_data    write data, stable while reg_wr_req is high
//   reg_wr_ack     downstream acceptance of the write
//   err_sync       pulse: byte discarded while hunting for the sync byte
//   err_timeout    pulse: partial packet aborted on inter-byte timeout
//   err_chksum     pulse: packet dropped on checksum mismatch
// -----------------------------------------------------------------------------
module rs232_cmd_ctrl #(
  parameter int unsigned P_CLK_FREQ_HZ = 100000000,
  parameter int unsigned P_TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  P_SYNC_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_fifo_empty,
  output logic       rx_fifo_rd_en,
  input  logic [7:0] rx_fifo_dout,
  output logic       reg_wr_req,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic       reg_wr_ack,
  output logic       err_sync,
  output logic       err_timeout,
  output logic       err_chksum
);

  // The clock frequency only gives the timeout a wall-clock meaning; the
  // elaboration check below rejects settings that make the timeout useless.
  if (P_TIMEOUT_CYC < 2 || P_CLK_FREQ_HZ == 0) begin : g_bad_param
    $error("rs232_cmd_ctrl: P_TIMEOUT_CYC must be >= 2 and P_CLK_FREQ_HZ > 0");
  end

  localparam int unsigned CNT_W = $clog2(P_TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(P_TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,  // idle, waiting for a byte in the FIFO
    S_POP   = 2'd1,  // rx_fifo_rd_en high for this one cycle
    S_CAP   = 2'd2,  // rx_fifo_dout valid, consume it
    S_WRITE = 2'd3   // reg_wr_req high until acknowledged
  } state_t;

  // Field index of the next expected byte.
  localparam logic [1:0] FLD_SYNC = 2'd0;
  localparam logic [1:0] FLD_ADDR = 2'd1;
  localparam logic [1:0] FLD_DATA = 2'd2;
  localparam logic [1:0] FLD_CHK  = 2'd3;

  // NOTE: declaration initialisers give the power-up state on FPGA targets;
  // the asynchronous reset below still defines the state everywhere else.
  state_t           state      = S_WAIT;
  logic [1:0]       fld        = FLD_SYNC;
  logic [CNT_W-1:0] tmo_cnt    = '0;
  logic             rd_en_q    = 1'b0;
  logic             wr_req_q   = 1'b0;
  logic [7:0]       wr_addr_q  = 8'h00;
  logic [7:0]       wr_data_q  = 8'h00;
  logic             err_sync_q = 1'b0;
  logic             err_tmo_q  = 1'b0;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
  logic             err_chk_q  = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the values from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      fld        <= FLD_SYNC;
      tmo_cnt    <= '0;
      rd_en_q    <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      err_sync_q <= 1'b0;
      err_tmo_q  <= 1'b0;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
      err_chk_q  <= 1'b0;
`endif
    end else begin
      // NOTE: error flags default low every cycle so each assertion below is
      // a single-cycle pulse without needing an explicit clear elsewhere.
      err_sync_q <= 1'b0;
      err_tmo_q  <= 1'b0;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
      err_chk_q  <= 1'b0;
`endif

      unique case (state)
        S_WAIT: begin
          if (fld != FLD_SYNC && tmo_cnt == TMO_MAX) begin
            // Timeout takes priority over a waiting byte; that byte is
            // popped on the next cycle and hunted for sync.
            err_tmo_q <= 1'b1;
            fld       <= FLD_SYNC;
            tmo_cnt   <= '0;
          end else begin
            // Reaching TMO_MAX always takes the branch above, so the
            // increment here can never run past the saturation value.
            if (fld != FLD_SYNC) tmo_cnt <= tmo_cnt + 1'b1;
            if (!rx_fifo_empty) begin
              state   <= S_POP;
              rd_en_q <= 1'b1;
            end
          end
        end

        S_POP: begin
          rd_en_q <= 1'b0;
          state   <= S_CAP;
        end

        S_CAP: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
          case (fld)
            FLD_SYNC: begin
              if (rx_fifo_dout == P_SYNC_BYTE) fld <= FLD_ADDR;
              else err_sync_q <= 1'b1;
            end
            FLD_ADDR: begin
              wr_addr_q <= rx_fifo_dout;
              fld       <= FLD_DATA;
            end
            FLD_DATA: begin
              wr_data_q <= rx_fifo_dout;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
              fld       <= FLD_CHK;
`else
              fld       <= FLD_SYNC;
              wr_req_q  <= 1'b1;
              state     <= S_WRITE;
`endif
            end
            default: begin
              fld <= FLD_SYNC;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
              if (rx_fifo_dout == 8'(wr_addr_q + wr_data_q)) begin
                wr_req_q <= 1'b1;
                state    <= S_WRITE;
              end else begin
                err_chk_q <= 1'b1;
              end
`endif
            end
          endcase
        end

        S_WRITE: begin
          // An ack outside this state is simply never looked at.
          if (reg_wr_ack) begin
            wr_req_q <= 1'b0;
            state    <= S_WAIT;
          end
        end

        default: state <= S_WAIT;
      endcase
    end
  end

  assign rx_fifo_rd_en = rd_en_q;
  assign reg_wr_req    = wr_req_q;
  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;
  assign err_sync      = err_sync_q;
  assign err_timeout   = err_tmo_q;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
  assign err_chksum    = err_chk_q;
`else
  assign err_chksum    = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rs232_cmd_ctrl
// Self-checking bench for rs232_cmd_ctrl. A behavioural FIFO and a register
// slave with programmable ack delay surround the DUT; a table of packets with
// hand-computed results is applied, followed by hand-written timeout and
// reset-during-write sequences. Follows the RS232_CMD_CTRL_CHKSUM_EN build.
// -----------------------------------------------------------------------------
module tb_rs232_cmd_ctrl;

  localparam int TMO = 50;

  logic       clk           = 1'b0;
  logic       rst_n         = 1'b0;
  logic       rx_fifo_empty = 1'b1;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout  = 8'h00;
  logic       reg_wr_req;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_ack    = 1'b0;
  logic       err_sync;
  logic       err_timeout;
  logic       err_chksum;

  always #5 clk = ~clk;

  rs232_cmd_ctrl #(
    .P_CLK_FREQ_HZ(100000000),
    .P_TIMEOUT_CYC(TMO),
    .P_SYNC_BYTE  (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .rx_fifo_dout (rx_fifo_dout),
    .reg_wr_req   (reg_wr_req),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ack   (reg_wr_ack),
    .err_sync     (err_sync),
    .err_timeout  (err_timeout),
    .err_chksum   (err_chksum)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fifo_q[$];
  int         rd_pulses, sync_pulses, chk_pulses, tmo_pulses, wr_count, viol;
  int         req_cycles = 0;
  int         ack_delay  = 0;
  bit         ack_en     = 1'b1;
  bit         prev_req   = 1'b0;
  logic [7:0] wr_addr, wr_data, held_addr, held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    rd_pulses = 0; sync_pulses = 0; chk_pulses = 0; tmo_pulses = 0;
    wr_count  = 0; viol        = 0;
    wr_addr   = 8'hxx; wr_data = 8'hxx;
  endtask

  // All stimulus and checks happen 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_stats();
  endtask

  task automatic push_bytes(input int n, input logic [63:0] bytes);
    for (int j = 0; j < n; j++) fifo_q.push_back(bytes[8*(n-1-j) +: 8]);
  endtask

  // ---------------------------------------------------------------------------
  // FIFO model, register slave and protocol monitor (falling edge).
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rx_fifo_rd_en) begin
      rd_pulses++;
      if (fifo_q.size() == 0) viol++;
      else rx_fifo_dout = fifo_q.pop_front();
      if (reg_wr_req) viol++;
    end
    if (err_sync)    sync_pulses++;
    if (err_chksum)  chk_pulses++;
    if (err_timeout) tmo_pulses++;

    if (reg_wr_req) begin
      if (prev_req && (reg_wr_addr !== held_addr || reg_wr_data !== held_data)) viol++;
      held_addr = reg_wr_addr;
      held_data = reg_wr_data;
      if (reg_wr_ack) begin
        // The ack was seen on the last rising edge; req should have dropped.
        viol++;
        reg_wr_ack = 1'b0;
      end else begin
        req_cycles++;
        if (ack_en && req_cycles > ack_delay) begin
          reg_wr_ack = 1'b1;
          wr_count++;
          wr_addr = reg_wr_addr;
          wr_data = reg_wr_data;
        end
      end
    end else begin
      reg_wr_ack = 1'b0;
      req_cycles = 0;
    end
    prev_req      = reg_wr_req;
    rx_fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------------------------------------------------------------------
  // Vector table: bytes are listed first-byte-first in the top n bytes.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          ack_dly;
    int          exp_wr;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    int          exp_sync;
    int          exp_chk;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [63:0] b, input int ad, input int wr,
                              input logic [7:0] a, input logic [7:0] d, input int s, input int c);
    vec_t v;
    v.n = n; v.bytes = b; v.ack_dly = ad; v.exp_wr = wr;
    v.exp_addr = a; v.exp_data = d; v.exp_sync = s; v.exp_chk = c;
    return v;
  endfunction

`ifdef RS232_CMD_CTRL_CHKSUM_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif
  vec_t vecs[NV];

  initial begin
`ifdef RS232_CMD_CTRL_CHKSUM_EN
    vecs[0] = mk(4, 64'hA5102232,         2, 1, 8'h10, 8'h22, 0, 0);
    vecs[1] = mk(5, 64'h3CA5010203,       2, 1, 8'h01, 8'h02, 1, 0);
    vecs[2] = mk(8, 64'hA50102FFA5010203, 1, 1, 8'h01, 8'h02, 0, 1);
    vecs[3] = mk(4, 64'hA57F80FF,         0, 1, 8'h7F, 8'h80, 0, 0);
    vecs[4] = mk(6, 64'hFF00A5A5A54A,     3, 1, 8'hA5, 8'hA5, 2, 0);
    vecs[5] = mk(4, 64'hA5FF0100,         0, 1, 8'hFF, 8'h01, 0, 0);
`else
    vecs[0] = mk(3, 64'hA57F80,           2, 1, 8'h7F, 8'h80, 0, 0);
    vecs[1] = mk(4, 64'h3CA50102,         2, 1, 8'h01, 8'h02, 1, 0);
    vecs[2] = mk(6, 64'hA51022A53344,     0, 2, 8'h33, 8'h44, 0, 0);
    vecs[3] = mk(5, 64'hFF00A5A5A5,       1, 1, 8'hA5, 8'hA5, 2, 0);
    vecs[4] = mk(3, 64'hA5FF01,           3, 1, 8'hFF, 8'h01, 0, 0);
`endif

    // Reset state while rst_n is held low.
    clear_stats();
    step(2);
    check("rst rd_en",       32'(rx_fifo_rd_en), 0);
    check("rst wr_req",      32'(reg_wr_req),    0);
    check("rst wr_addr",     32'(reg_wr_addr),   0);
    check("rst wr_data",     32'(reg_wr_data),   0);
    check("rst err_sync",    32'(err_sync),      0);
    check("rst err_timeout", 32'(err_timeout),   0);
    check("rst err_chksum",  32'(err_chksum),    0);
    rst_n = 1'b1;
    step(10);
    check("idle rd_pulses", 32'(rd_pulses), 0);

    // Table-driven packets.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      ack_en    = 1'b1;
      ack_delay = vecs[i].ack_dly;
      push_bytes(vecs[i].n, vecs[i].bytes);
      step(80);
      check($sformatf("v%0d writes", i),    32'(wr_count),    32'(vecs[i].exp_wr));
      check($sformatf("v%0d addr", i),      32'(wr_addr),     32'(vecs[i].exp_addr));
      check($sformatf("v%0d data", i),      32'(wr_data),     32'(vecs[i].exp_data));
      check($sformatf("v%0d err_sync", i),  32'(sync_pulses), 32'(vecs[i].exp_sync));
      check($sformatf("v%0d err_chk", i),   32'(chk_pulses),  32'(vecs[i].exp_chk));
      check($sformatf("v%0d err_tmo", i),   32'(tmo_pulses),  0);
      check($sformatf("v%0d rd_pulses", i), 32'(rd_pulses),   32'(vecs[i].n));
      check($sformatf("v%0d protocol", i),  32'(viol),        0);
    end

    // Inter-byte timeout: A5,01 then silence, then 02,03 hunted as non-sync.
    do_reset();
    ack_delay = 0;
    push_bytes(2, 64'hA501);
    step(6 + TMO - 3);
    check("tmo early", 32'(tmo_pulses), 0);
    step(2 * TMO);
    check("tmo once",      32'(tmo_pulses),  1);
    check("tmo no sync",   32'(sync_pulses), 0);
    push_bytes(2, 64'h0203);
    step(30);
    check("tmo post sync", 32'(sync_pulses), 2);
    check("tmo post tmo",  32'(tmo_pulses),  1);
    check("tmo post wr",   32'(wr_count),    0);
    check("tmo rd_pulses", 32'(rd_pulses),   4);
    check("tmo protocol",  32'(viol),        0);

    // Reset while a write request is outstanding.
    do_reset();
    ack_en = 1'b0;
`ifdef RS232_CMD_CTRL_CHKSUM_EN
    push_bytes(4, 64'hA5010203);
`else
    push_bytes(3, 64'hA50102);
`endif
    for (int k = 0; k < 40 && !reg_wr_req; k++) step(1);
    check("mid req high", 32'(reg_wr_req), 1);
    rst_n = 1'b0;
    #1;
    check("mid req async clr", 32'(reg_wr_req), 0);
    fifo_q.delete();
    step(2);
    rst_n = 1'b1;
    clear_stats();
    ack_en = 1'b1;
    step(20);
    check("mid post writes", 32'(wr_count),   0);
    check("mid post rd",     32'(rd_pulses),  0);
    check("mid post req",    32'(reg_wr_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs232_cmd_ctrl.md
RS232_CMD_CTRL -- requirements
Module: rs232_cmd_ctrl

Interface
REQ-001 Parameter P_CLK_FREQ_HZ, default 100000000, input clock frequency in Hz (informational; sets timeout scale).
REQ-002 Parameter P_TIMEOUT_CYC, default 1000000, inter-byte timeout in clk cycles (>=2).
REQ-003 Parameter P_SYNC_BYTE, default 8'hA5, packet start marker.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_fifo_empty  input  1  receive byte FIFO empty flag.
REQ-007 rx_fifo_rd_en  output  1  one-cycle FIFO pop strobe.
REQ-008 rx_fifo_dout  input  8  FIFO read data, valid the cycle after rx_fifo_rd_en.
REQ-009 reg_wr_req  output  1  register write request, held until acknowledged.
REQ-010 reg_wr_addr  output  8  register address, stable while reg_wr_req high.
REQ-011 reg_wr_data  output  8  register data, stable while reg_wr_req high.
REQ-012 reg_wr_ack  input  1  downstream acceptance of the write.
REQ-013 err_sync  output  1  one-cycle pulse: byte discarded while hunting for P_SYNC_BYTE.
REQ-014 err_timeout  output  1  one-cycle pulse: packet aborted on inter-byte timeout.
REQ-015 err_chksum  output  1  one-cycle pulse: packet dropped on checksum mismatch.

Function
REQ-016 Packet format, in order: SYNC (P_SYNC_BYTE), ADDR, DATA, CHK; 2-bit field index fld tracks the next expected field (0..3).
REQ-017 States: S_WAIT (idle/wait for data), S_POP (rx_fifo_rd_en=1 for exactly one cycle), S_CAP (capture rx_fifo_dout), S_WRITE (reg_wr_req high).
REQ-018 S_WAIT -> S_POP when rx_fifo_empty=0; S_POP -> S_CAP unconditionally; rx_fifo_rd_en never asserts when rx_fifo_empty=1.
REQ-019 S_CAP, fld=0: byte==P_SYNC_BYTE -> fld=1; else err_sync pulse, fld stays 0; -> S_WAIT.
REQ-020 S_CAP, fld=1: latch ADDR, fld=2; fld=2: latch DATA, fld=3; -> S_WAIT.
REQ-021 S_CAP, fld=3: CHK==(ADDR+DATA) mod 256 -> S_WRITE; else err_chksum pulse, -> S_WAIT; fld=0 in both cases.
REQ-022 S_WRITE: reg_wr_req=1 with latched address/data; on reg_wr_ack=1 sampled, reg_wr_req deasserts next cycle and state -> S_WAIT; no FIFO pop occurs during S_WRITE.
REQ-023 Timeout counter clears on every S_CAP; increments each cycle in S_WAIT while fld!=0; saturates at P_TIMEOUT_CYC.
REQ-024 Counter reaching P_TIMEOUT_CYC in S_WAIT with fld!=0: err_timeout pulse, fld=0, counter clear; if rx_fifo_empty=0 in that same cycle, timeout wins and the pop starts next cycle.
REQ-025 Timeout inactive when fld=0 and in S_POP/S_CAP/S_WRITE.
REQ-026 Throughput: one FIFO byte consumed per 3 cycles minimum; a full packet with immediate ack produces reg_wr_req 1 cycle after the CHK capture.
REQ-027 reg_wr_ack while reg_wr_req=0 is ignored; at most one error pulse per captured byte.

Reset
REQ-028 rst_n low: state=S_WAIT, fld=0, counter=0, rx_fifo_rd_en=0, reg_wr_req=0, reg_wr_addr=8'h00, reg_wr_data=8'h00, all err_* =0, asynchronously.
REQ-029 Reset mid-packet or mid-write drops the packet; no write is issued after reset release for bytes captured before reset.
REQ-030 All registers also initialised to their reset values at declaration for power-up.

Configuration
REQ-031 Macro RS232_CMD_CTRL_CHKSUM_EN defined: packet is SYNC/ADDR/DATA/CHK per REQ-016..021.
REQ-032 Macro undefined: packet is SYNC/ADDR/DATA; fld wraps 2->0 and S_CAP -> S_WRITE after DATA; err_chksum tied 0.

Verification (with RS232_CMD_CTRL_CHKSUM_EN unless stated)
REQ-033 FIFO holds A5,10,22,32; ack 2 cycles after req -> one write addr 8'h10 data 8'h22, four rd_en pulses, no errors.
REQ-034 FIFO holds 3C,A5,01,02,03 -> err_sync once for 3C, then write addr 8'h01 data 8'h02.
REQ-035 FIFO holds A5,01,02,FF -> err_chksum once, no reg_wr_req; following A5,01,02,03 writes normally.
REQ-036 A5,01 then FIFO empty for P_TIMEOUT_CYC cycles -> err_timeout exactly once, fld=0; later 02,03 produce two err_sync pulses.
REQ-037 rst_n asserted while reg_wr_req=1 -> reg_wr_req=0 immediately; after release, empty FIFO -> no write, rx_fifo_rd_en stays 0.
REQ-038 Macro undefined, FIFO holds A5,7F,80 -> write addr 8'h7F data 8'h80 after three pops.
